// File: rtl/bram_pkg.sv
// Shared types and register map for the multi-region backup RAM.
package bram_pkg;

  localparam int unsigned BRAM_REG_DIRTY   = 0;
  localparam int unsigned BRAM_REG_CNT0    = 1;
  localparam int unsigned BRAM_MAX_REGIONS = 4;

  typedef logic [2*BRAM_MAX_REGIONS-1:0] dirty_t;

  typedef struct packed {
    logic        ce;
    logic [15:0] addr;
    logic [7:0]  din;
  } mem_ctrl_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dato;
    logic        we;
  } pi_bus_t;

endpackage

// File: rtl/ram_dp.sv
// Simple true dual-port synchronous RAM, read-first, one cycle read latency.
module ram_dp #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  output logic [DW-1:0] dout_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] din_b,
  output logic [DW-1:0] dout_b
);

  logic [DW-1:0] ram [2**AW];

  always_ff @(posedge clk) begin
    if (we_a) ram[addr_a] <= din_a;
    if (we_b) ram[addr_b] <= din_b;
    dout_a <= ram[addr_a];
    dout_b <= ram[addr_b];
  end

endmodule

// File: rtl/bram_multi.sv
// Multi-region backup RAM with dirty tracking and idle-based save request.
// Optional per-region write counters are built when BRAM_WCNT_EN is defined.
module bram_multi
  import bram_pkg::*;
#(
  parameter int unsigned REGIONS  = 2,
  parameter int unsigned RAW      = 13,
  parameter int unsigned IDLE_CYC = 65536
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   brm_on,
  input  logic                   brm_bc_on,
  input  logic                   cpu_we_sync,
  input  mem_ctrl_t              mem [REGIONS],
  output logic [7:0]             brm_dato,
  input  pi_bus_t                pi,
  input  logic                   pi_ce,
  output logic [7:0]             pi_dato,
  output logic [2*REGIONS-1:0]   dirty,
  output logic                   bc_req
);

  localparam int unsigned AW = RAW + 2;
  localparam int unsigned DW = 2 * REGIONS;
  localparam int unsigned IW = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;

  logic [1:0]     win;
  logic           any_ce;
  logic [RAW-1:0] cpu_addr;
  logic [7:0]     cpu_din;
  logic           rst_hold_q;
  logic           cpu_wr, track_on, host_ram_we, reg0_we;
  logic [DW-1:0]  dirty_q, dirty_d;
  logic [IW-1:0]  idle_q, idle_d;
  logic           bc_req_q, bc_req_d;
  logic [7:0]     reg_rd, ram_dout_b;
  logic           unused_in;

  // Descending scan so the lowest asserted ce is the last assignment.
  always_comb begin
    win      = '0;
    any_ce   = 1'b0;
    cpu_addr = mem[0].addr[RAW-1:0];
    cpu_din  = mem[0].din;
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if (mem[i].ce) begin
        win      = 2'(i);
        any_ce   = 1'b1;
        cpu_addr = mem[i].addr[RAW-1:0];
        cpu_din  = mem[i].din;
      end
    end
  end

  // Blocks a strobe that straddles reset release from writing on the first edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_hold_q <= 1'b1;
    else     rst_hold_q <= 1'b0;
  end

  assign cpu_wr      = any_ce & cpu_we_sync & brm_on & ~rst & ~rst_hold_q;
  assign track_on    = brm_on & brm_bc_on;
  assign host_ram_we = pi_ce & pi.we & ~pi.addr[15];
  assign reg0_we     = pi_ce & pi.we & pi.addr[15] & (pi.addr[14:0] == 15'(BRAM_REG_DIRTY));
  assign unused_in   = ^{pi.dato, mem[0].addr};

  ram_dp #(
    .AW(AW),
    .DW(8)
  ) u_ram (
    .clk    (clk),
    .we_a   (cpu_wr),
    .addr_a ({win, cpu_addr}),
    .din_a  (cpu_din),
    .dout_a (brm_dato),
    .we_b   (host_ram_we),
    .addr_b (pi.addr[AW-1:0]),
    .din_b  (pi.dato),
    .dout_b (ram_dout_b)
  );

  always_comb begin
    dirty_d = dirty_q;
    if (!track_on) begin
      dirty_d = '0;
    end else begin
      if (reg0_we) dirty_d = dirty_q & pi.dato[DW-1:0];
      for (int i = 0; i < REGIONS; i++) begin
        if (cpu_wr && win == 2'(i)) dirty_d[2*i +: 2] = 2'b11;
      end
    end
  end

  always_comb begin
    idle_d = idle_q;
    if (!track_on || cpu_wr || dirty_d == '0) idle_d = '0;
    else if (idle_q != IW'(IDLE_CYC))         idle_d = idle_q + 1'b1;
    bc_req_d = track_on && (dirty_d != '0) && (idle_q == IW'(IDLE_CYC));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dirty_q  <= '0;
      idle_q   <= '0;
      bc_req_q <= 1'b0;
    end else begin
      dirty_q  <= dirty_d;
      idle_q   <= idle_d;
      bc_req_q <= bc_req_d;
    end
  end

`ifdef BRAM_WCNT_EN
  logic [7:0] cnt_q [REGIONS];
  logic [7:0] cnt_d [REGIONS];

  // A write in the same cycle as a clear leaves the counter at one.
  always_comb begin
    for (int i = 0; i < REGIONS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!track_on) begin
        cnt_d[i] = '0;
      end else begin
        if (reg0_we && pi.dato[2*i +: 2] == 2'b00) cnt_d[i] = '0;
        if (cpu_wr && win == 2'(i) && cnt_d[i] != 8'hFF) cnt_d[i] = cnt_d[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGIONS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < REGIONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`endif

  always_comb begin
    reg_rd = '0;
    if (pi.addr[14:0] == 15'(BRAM_REG_DIRTY)) reg_rd[DW-1:0] = dirty_q;
`ifdef BRAM_WCNT_EN
    for (int i = 0; i < REGIONS; i++) begin
      if (pi.addr[14:0] == 15'(BRAM_REG_CNT0 + i)) reg_rd = cnt_q[i];
    end
`endif
  end

  assign pi_dato = pi.addr[15] ? reg_rd : ram_dout_b;
  assign dirty   = dirty_q;
  assign bc_req  = bc_req_q;

endmodule

// File: tb/tb_bram_multi.sv
// Directed self-checking bench for bram_multi (REGIONS=2, RAW=13, IDLE_CYC=16).
module tb_bram_multi;
  import bram_pkg::*;

  logic       clk = 1'b0;
  logic       rst, brm_on, brm_bc_on, cpu_we_sync, pi_ce, bc_req;
  mem_ctrl_t  mem [2];
  pi_bus_t    pi;
  logic [7:0] brm_dato, pi_dato, d;
  logic [3:0] dirty;
  int         checks = 0;
  int         errors = 0;

  bram_multi #(
    .REGIONS  (2),
    .RAW      (13),
    .IDLE_CYC (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .brm_on      (brm_on),
    .brm_bc_on   (brm_bc_on),
    .cpu_we_sync (cpu_we_sync),
    .mem         (mem),
    .brm_dato    (brm_dato),
    .pi          (pi),
    .pi_ce       (pi_ce),
    .pi_dato     (pi_dato),
    .dirty       (dirty),
    .bc_req      (bc_req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input int r, input logic [15:0] a, input logic [7:0] v);
    mem[r].ce = 1'b1; mem[r].addr = a; mem[r].din = v; cpu_we_sync = 1'b1;
    tick();
    mem[r].ce = 1'b0; cpu_we_sync = 1'b0;
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [7:0] v);
    pi.addr = a; pi.dato = v; pi.we = 1'b1; pi_ce = 1'b1;
    tick();
    pi.we = 1'b0; pi_ce = 1'b0;
  endtask

  task automatic host_rd(input logic [15:0] a, output logic [7:0] v);
    pi.addr = a; pi.we = 1'b0; pi_ce = 1'b1;
    tick();
    v = pi_dato; pi_ce = 1'b0;
  endtask

  task automatic reg_rd(input logic [15:0] a, output logic [7:0] v);
    pi.addr = a; pi.we = 1'b0; pi_ce = 1'b1;
    #1;
    v = pi_dato; pi_ce = 1'b0;
  endtask

  initial begin
    rst = 1'b1; brm_on = 1'b1; brm_bc_on = 1'b1; cpu_we_sync = 1'b0; pi_ce = 1'b0;
    pi = '0;
    mem[0] = '0; mem[1] = '0;
    tick(); tick();
    check("reset_dirty", 32'(dirty), 32'h0);
    check("reset_bc_req", 32'(bc_req), 32'h0);
    rst = 1'b0;
    tick(); tick();
    reg_rd(16'h8000, d);
    check("reset_reg0", 32'(d), 32'h00);

    // Region 1 write and idle countdown to save request
    cpu_write(1, 16'h0010, 8'h5A);
    check("wr_r1_dirty", 32'(dirty), 32'hC);
    repeat (16) tick();
    check("idle_16_no_req", 32'(bc_req), 32'h0);
    tick();
    check("idle_17_req", 32'(bc_req), 32'h1);
    host_rd(16'h2010, d);
    check("host_rd_2010", 32'(d), 32'h5A);

    // Clearing all dirty bits drops the request; second write restarts the count
    host_wr(16'h8000, 8'h00);
    check("clr_dirty", 32'(dirty), 32'h0);
    check("clr_bc_req", 32'(bc_req), 32'h0);
    cpu_write(1, 16'h0010, 8'h5A);
    repeat (9) tick();
    cpu_write(1, 16'h0011, 8'h5B);
    repeat (7) tick();
    check("restart_e17_no_req", 32'(bc_req), 32'h0);
    repeat (9) tick();
    check("restart_e26_no_req", 32'(bc_req), 32'h0);
    tick();
    check("restart_e27_req", 32'(bc_req), 32'h1);

    // Dropping brm_bc_on clears tracking
    brm_bc_on = 1'b0;
    tick();
    check("bc_off_dirty", 32'(dirty), 32'h0);
    check("bc_off_req", 32'(bc_req), 32'h0);
    brm_bc_on = 1'b1;

    // Host clear and region-0 write in the same cycle
    cpu_write(1, 16'h0012, 8'h01);
    repeat (17) tick();
    check("pre_f3_req", 32'(bc_req), 32'h1);
    pi.addr = 16'h8000; pi.dato = 8'hF3; pi.we = 1'b1; pi_ce = 1'b1;
    cpu_write(0, 16'h0012, 8'h02);
    pi.we = 1'b0; pi_ce = 1'b0;
    check("f3_dirty", 32'(dirty), 32'h3);
    check("f3_bc_req", 32'(bc_req), 32'h1);
    reg_rd(16'h8000, d);
    check("f3_reg0", 32'(d), 32'h03);

    // Two regions selected at once: only region 0 is written
    cpu_write(1, 16'h0030, 8'h3C);
    host_wr(16'h8000, 8'h00);
    mem[0].ce = 1'b1; mem[0].addr = 16'h0030; mem[0].din = 8'hA5;
    mem[1].ce = 1'b1; mem[1].addr = 16'h0030; mem[1].din = 8'hA5;
    cpu_we_sync = 1'b1;
    tick();
    mem[0].ce = 1'b0; mem[1].ce = 1'b0; cpu_we_sync = 1'b0;
    check("dual_dirty", 32'(dirty), 32'h3);
    host_rd(16'h0030, d);
    check("dual_r0", 32'(d), 32'hA5);
    host_rd(16'h2030, d);
    check("dual_r1", 32'(d), 32'h3C);
    mem[0].ce = 1'b1; mem[0].addr = 16'h0030;
    tick();
    mem[0].ce = 1'b0;
    check("cpu_rd", 32'(brm_dato), 32'hA5);

    // Write counters
    host_wr(16'h8000, 8'h00);
    mem[0].ce = 1'b1; mem[0].addr = 16'h0060; mem[0].din = 8'h60; cpu_we_sync = 1'b1;
    repeat (300) tick();
    mem[0].ce = 1'b0; cpu_we_sync = 1'b0;
    check("cnt_dirty", 32'(dirty), 32'h3);
    reg_rd(16'h8001, d);
`ifdef BRAM_WCNT_EN
    check("cnt_sat", 32'(d), 32'hFF);
`else
    check("cnt_absent", 32'(d), 32'h00);
`endif
    host_wr(16'h8000, 8'hFC);
    check("cnt_clr_dirty", 32'(dirty), 32'h0);
    reg_rd(16'h8001, d);
    check("cnt_cleared", 32'(d), 32'h00);
    reg_rd(16'h8005, d);
    check("reg_unmapped", 32'(d), 32'h00);

    // brm_on=0 blocks CPU writes but not host RAM access
    cpu_write(0, 16'h0040, 8'h44);
    brm_on = 1'b0;
    cpu_write(0, 16'h0040, 8'h99);
    check("off_dirty", 32'(dirty), 32'h0);
    host_rd(16'h0040, d);
    check("off_blocked", 32'(d), 32'h44);
    host_wr(16'h0050, 8'h66);
    host_rd(16'h0050, d);
    check("off_host_ram", 32'(d), 32'h66);
    brm_on = 1'b1;

    // Reset mid-count, with a write strobe straddling reset release
    cpu_write(0, 16'h0020, 8'h11);
    cpu_write(1, 16'h0010, 8'h22);
    repeat (5) tick();
    check("pre_rst_dirty", 32'(dirty), 32'hF);
    mem[0].ce = 1'b1; mem[0].addr = 16'h0020; mem[0].din = 8'h77; cpu_we_sync = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_async_dirty", 32'(dirty), 32'h0);
    check("rst_async_req", 32'(bc_req), 32'h0);
    @(posedge clk);
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
    mem[0].ce = 1'b0; cpu_we_sync = 1'b0;
    check("rst_rel_dirty", 32'(dirty), 32'h0);
    host_rd(16'h0020, d);
    check("rst_no_write", 32'(d), 32'h11);
    host_rd(16'h2010, d);
    check("rst_ram_kept", 32'(d), 32'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_multi.md
BRAM_MULTI -- requirements
Module: bram_multi

Interface
REQ-001 Parameter REGIONS, default 2, number of independent backup-RAM regions; legal range 1..4.
REQ-002 Parameter RAW, default 13, byte-address width of each region (region size 2^RAW).
REQ-003 Parameter IDLE_CYC, default 65536, number of write-free cycles required before a save request is raised; 0 means immediate.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 brm_on  in  1  enables memory writes and dirty tracking.
REQ-007 brm_bc_on  in  1  enables dirty tracking and the save request.
REQ-008 cpu_we_sync  in  1  single-cycle CPU write strobe.
REQ-009 mem  in  MemCtrl[REGIONS]  per-region CPU access; mem[i].ce selects region i.
REQ-010 brm_dato  out  8  CPU read data, one cycle after the address.
REQ-011 pi  in  PiBus  host interface bus.
REQ-012 pi_ce  in  1  host chip-select for this block.
REQ-013 pi_dato  out  8  host read data.
REQ-014 dirty  out  2*REGIONS  per-region dirty pair; region i occupies bits [2i+1:2i].
REQ-015 bc_req  out  1  save request to host.

Function
REQ-016 CPU arbitration: lowest asserted mem[i].ce index wins; physical address = {i, mem[i].addr[RAW-1:0]}.
REQ-017 CPU write = winner ce & cpu_we_sync & brm_on; exactly one RAM write per strobe.
REQ-018 With no ce asserted, region 0 address is used for reads and no write occurs.
REQ-019 Host map: pi.addr[15]=0 is RAM (pi.addr[RAW+1:0]); pi.addr[15]=1 is registers.
REQ-020 Register 0 read returns the dirty vector, zero-padded to 8 bits; register 0 write ANDs the dirty vector with pi.dato (1 = keep, 0 = clear).
REQ-021 Registers 1..REGIONS read per-region write counters (see Configuration); all other register offsets read 0x00.
REQ-022 Register reads are combinational from pi.addr; RAM reads on port B take one cycle.
REQ-023 CPU write to region i sets dirty[2i+1:2i] to 2'b11 on the next edge.
REQ-024 CPU write and host clear to the same region in the same cycle: the write wins (pair = 11); other regions take the clear.
REQ-025 Idle counter: cleared on any CPU write; increments while dirty != 0 and below IDLE_CYC; saturates at IDLE_CYC.
REQ-026 bc_req = (dirty != 0) & (idle counter == IDLE_CYC), registered.
REQ-027 Clearing all dirty bits deasserts bc_req on the following edge and zeroes the idle counter.
REQ-028 brm_on=0 or brm_bc_on=0 synchronously clears dirty, the idle counter, bc_req and the counters; with brm_on=0 CPU writes are also blocked; host RAM access remains available.

Reset
REQ-029 rst asynchronously clears dirty, the idle counter and all counters to 0, and forces bc_req to 0.
REQ-030 RAM contents are not cleared by rst.
REQ-031 Deasserting rst in the middle of a write strobe performs no write in the reset cycle.

Configuration
REQ-032 With BRAM_WCNT_EN defined: per-region 8-bit saturating counters increment on each CPU write to the region and clear on a register-0 write that clears both bits of that region's pair.
REQ-033 Without BRAM_WCNT_EN: no counters are built; registers 1..REGIONS read 0x00.

Structure
REQ-034 Package bram_pkg holds BRAM_REG_DIRTY=0, BRAM_REG_CNT0=1, the maximum REGIONS (4) and the dirty-vector typedef.
REQ-035 The block instantiates one existing ram_dp sized 2^(RAW+2) bytes; no other sub-module.

Verification
REQ-036 Reset, then a CPU write of 0x5A to region 1 address 0x010 -> dirty=4'b1100; a host read of RAM 0x2010 returns 0x5A.
REQ-037 IDLE_CYC=16, a single write -> bc_req rises exactly 17 cycles after the strobe; a second write at cycle 10 restarts the count.
REQ-038 A host register-0 write of 0xF3 in the same cycle as a region-0 write -> dirty=4'b0011, bc_req unchanged.
REQ-039 Regions 0 and 1 selected together during a write of 0xA5 -> only region 0 is written; the region-1 location is unchanged.
REQ-040 With BRAM_WCNT_EN: 300 writes to region 0 -> register 1 reads 0xFF; clear pair 0 -> register 1 reads 0x00.
REQ-041 brm_bc_on dropped while bc_req=1 -> dirty=0 and bc_req=0 next cycle; rst mid-count -> all tracking state 0.
